mb_write_frame_builder: RTL and testbench



---
 rtl/mb_write_frame_builder_if.sv | 24 ++
 rtl/mb_write_frame_builder.sv | 211 +++++++++++++++++++++
 tb/tb_mb_write_frame_builder.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mb_write_frame_builder_if.sv
// rtl/mb_write_frame_builder_if.sv - register-mux selector/data and UART byte stream bundle
interface mb_write_frame_builder_if;
    logic [7:0]  selector;
    logic [15:0] data_in;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output selector,
        input  data_in,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  selector,
        output data_in,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/mb_write_frame_builder.sv
// rtl/mb_write_frame_builder.sv - Modbus RTU function 0x10 request framer with CRC-16/MODBUS
module mb_write_frame_builder #(
    parameter int unsigned MAX_REGS  = 123,
    parameter logic [7:0]  FUNC_CODE = 8'h10
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    input  logic                        start_i,
    input  logic [7:0]                  adr_i,
    input  logic [15:0]                 adr_first_reg_tx_i,
    input  logic [7:0]                  num_reg_tx_i,
    mb_write_frame_builder_if.master    bus,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_WAITD = 3'd3;
    localparam logic [2:0] S_DHI   = 3'd4;
    localparam logic [2:0] S_DLO   = 3'd5;
    localparam logic [2:0] S_CRCL  = 3'd6;
    localparam logic [2:0] S_CRCH  = 3'd7;

    localparam logic [8:0] MAX_N = 9'(MAX_REGS);

    logic [2:0]  state_q, state_d;
    logic [2:0]  hdr_idx_q, hdr_idx_d;
    logic [7:0]  adr_q, adr_d;
    logic [15:0] reg_q, reg_d;
    logic [7:0]  n_q, n_d;
    logic [7:0]  sel_q, sel_d;
    logic [7:0]  dlo_q, dlo_d;
    logic [15:0] crc_q, crc_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        xfer;
    logic        n_ok;
    logic [15:0] crc_upd;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] b);
        logic [15:0] c;
        c = crc_in ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) c = (c >> 1) ^ 16'hA001;
            else      c = c >> 1;
        end
        return c;
    endfunction

    // Header bytes after the address, taken from the snapshot registers
    function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [7:0] a,
                                            input logic [15:0] r, input logic [7:0] n);
        logic [7:0] b;
        case (idx)
            3'd0:    b = a;
            3'd1:    b = FUNC_CODE;
            3'd2:    b = r[15:8];
            3'd3:    b = r[7:0];
            3'd4:    b = 8'h00;
            3'd5:    b = n;
            3'd6:    b = {n[6:0], 1'b0};
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign xfer    = tx_valid_q & bus.tx_ready;
    assign n_ok    = (num_reg_tx_i != 8'd0) && ({1'b0, num_reg_tx_i} <= MAX_N);
    assign crc_upd = crc16_byte(crc_q, tx_data_q);

    always_comb begin
        state_d    = state_q;
        hdr_idx_d  = hdr_idx_q;
        adr_d      = adr_q;
        reg_d      = reg_q;
        n_d        = n_q;
        sel_d      = sel_q;
        dlo_d      = dlo_q;
        crc_d      = crc_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (n_ok) begin
                        adr_d      = adr_i;
                        reg_d      = adr_first_reg_tx_i;
                        n_d        = num_reg_tx_i;
                        crc_d      = 16'hFFFF;
                        tx_data_d  = adr_i;
                        tx_valid_d = 1'b1;
                        busy_d     = 1'b1;
                        hdr_idx_d  = 3'd0;
                        state_d    = S_HDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_HDR: begin
                if (xfer) begin
                    crc_d = crc_upd;
                    if (hdr_idx_q == 3'd6) begin
                        tx_valid_d = 1'b0;
                        sel_d      = 8'd1;
                        state_d    = S_FETCH;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 3'd1;
                        tx_data_d = hdr_byte(hdr_idx_q + 3'd1, adr_q, reg_q, n_q);
                    end
                end
            end
            S_FETCH: state_d = S_WAITD;
            S_WAITD: begin
                // Mux output reflects the selector set on entry to FETCH
                tx_data_d  = bus.data_in[15:8];
                dlo_d      = bus.data_in[7:0];
                tx_valid_d = 1'b1;
                state_d    = S_DHI;
            end
            S_DHI: begin
                if (xfer) begin
                    crc_d     = crc_upd;
                    tx_data_d = dlo_q;
                    state_d   = S_DLO;
                end
            end
            S_DLO: begin
                if (xfer) begin
                    crc_d = crc_upd;
                    if (sel_q < n_q) begin
                        sel_d      = sel_q + 8'd1;
                        tx_valid_d = 1'b0;
                        state_d    = S_FETCH;
                    end else begin
                        sel_d     = 8'd0;
                        tx_data_d = crc_upd[7:0];
                        state_d   = S_CRCL;
                    end
                end
            end
            S_CRCL: begin
                if (xfer) begin
                    tx_data_d = crc_q[15:8];
                    state_d   = S_CRCH;
                end
            end
            S_CRCH: begin
                if (xfer) begin
                    tx_data_d  = 8'h00;
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= S_IDLE;
            hdr_idx_q  <= 3'd0;
            adr_q      <= 8'h00;
            reg_q      <= 16'h0000;
            n_q        <= 8'h00;
            sel_q      <= 8'h00;
            dlo_q      <= 8'h00;
            crc_q      <= 16'hFFFF;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_idx_q  <= hdr_idx_d;
            adr_q      <= adr_d;
            reg_q      <= reg_d;
            n_q        <= n_d;
            sel_q      <= sel_d;
            dlo_q      <= dlo_d;
            crc_q      <= crc_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.selector = sel_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_mb_write_frame_builder.sv
// tb/tb_mb_write_frame_builder.sv - directed self-checking bench for the 0x10 request framer
module tb_mb_write_frame_builder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  adr;
    logic [15:0] first_reg;
    logic [7:0]  num;
    logic        busy;
    logic        done;
    logic        err;

    mb_write_frame_builder_if bus();

    mb_write_frame_builder dut (
        .clk_i              (clk),
        .reset_ni           (rst_n),
        .start_i            (start),
        .adr_i              (adr),
        .adr_first_reg_tx_i (first_reg),
        .num_reg_tx_i       (num),
        .bus                (bus),
        .busy_o             (busy),
        .done_o             (done),
        .err_o              (err)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [0:255];
    logic [7:0]  got_q [$];
    logic [7:0]  exp_q [$];
    logic [7:0]  sel_log [$];
    logic [7:0]  nom [0:10] = '{8'h01, 8'h10, 8'h01, 8'h2C, 8'h00, 8'h02,
                                8'h04, 8'h00, 8'h0A, 8'h01, 8'h02};
    int          first_cyc;
    int          done_cyc;
    bit          aborted;

    bit          bp_en       = 0;
    int          inj_a       = 0;
    int          inj_b       = 0;
    int          abort_at    = -1;
    bit          restart     = 0;
    logic [7:0]  rs_adr;
    logic [15:0] rs_first;
    logic [7:0]  rs_num;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered register mux: one clock from selector to data_out
    always @(posedge clk)
        bus.data_in <= (bus.selector == 8'd0) ? 16'h0000 : mem[bus.selector - 8'd1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_model(input logic [7:0] q [$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (q[i]) begin
            c = c ^ {8'h00, q[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    task automatic build_exp(input logic [7:0] a, input logic [15:0] f, input logic [7:0] n);
        logic [15:0] c;
        exp_q.delete();
        exp_q.push_back(a);
        exp_q.push_back(8'h10);
        exp_q.push_back(f[15:8]);
        exp_q.push_back(f[7:0]);
        exp_q.push_back(8'h00);
        exp_q.push_back(n);
        exp_q.push_back(8'(n * 2));
        for (int k = 0; k < int'(n); k++) begin
            exp_q.push_back(mem[k][15:8]);
            exp_q.push_back(mem[k][7:0]);
        end
        c = crc_model(exp_q);
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
    endtask

    task automatic run_frame();
        bit         stall_prev;
        logic [7:0] prev_byte;
        logic [7:0] last_sel;
        got_q.delete();
        sel_log.delete();
        first_cyc  = 0;
        done_cyc   = 0;
        aborted    = 0;
        stall_prev = 0;
        prev_byte  = 8'h00;
        last_sel   = 8'h00;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == inj_a || cyc == inj_b) begin
                start     = 1'b1;
                adr       = 8'h55;
                first_reg = 16'hBEEF;
                num       = 8'd7;
            end
            if (done) begin
                done_cyc = cyc;
                check("busy_low_at_done", 32'(busy), 32'd0);
                if (restart) begin
                    start     = 1'b1;
                    adr       = rs_adr;
                    first_reg = rs_first;
                    num       = rs_num;
                end
                break;
            end
            if (bus.selector != last_sel) begin
                sel_log.push_back(bus.selector);
                last_sel = bus.selector;
            end
            if (bus.tx_valid && first_cyc == 0) first_cyc = cyc;
            if (stall_prev)
                check("stall_hold", 32'({bus.tx_valid, bus.tx_data}), 32'({1'b1, prev_byte}));
            if (abort_at >= 0 && bus.tx_valid && got_q.size() == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("async_reset_outputs",
                      32'({bus.selector, bus.tx_data, bus.tx_valid, busy, done, err}), 32'd0);
                aborted = 1;
                break;
            end
            bus.tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
            stall_prev = bus.tx_valid && !bus.tx_ready;
            prev_byte  = bus.tx_data;
        end
        if (done_cyc == 0 && !aborted) check("frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic compare_frame(input string name);
        int m;
        check({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++)
            check($sformatf("%s_byte%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic check_sel(input logic [7:0] n);
        check("sel_len", 32'(sel_log.size()), 32'(n) + 32'd1);
        foreach (sel_log[i])
            check($sformatf("sel%0d", i), 32'(sel_log[i]), (i < int'(n)) ? 32'(i + 1) : 32'd0);
    endtask

    task automatic kick(input logic [7:0] a, input logic [15:0] f, input logic [7:0] n);
        adr       = a;
        first_reg = f;
        num       = n;
        start     = 1'b1;
    endtask

    task automatic err_case(input logic [7:0] n);
        @(negedge clk);
        kick(8'h01, 16'h0000, n);
        @(negedge clk);
        check($sformatf("err_pulse_n%0d", n), 32'({err, busy, bus.tx_valid}), 32'b100);
        start = 1'b0;
        @(negedge clk);
        check($sformatf("err_clear_n%0d", n), 32'({err, busy, bus.tx_valid}), 32'b000);
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        adr          = 8'h00;
        first_reg    = 16'h0000;
        num          = 8'h00;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = {8'(i) ^ 8'h5A, 8'(i) + 8'h11};
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({bus.selector, bus.tx_data, bus.tx_valid, busy, done, err}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal frame
        mem[0] = 16'h000A;
        mem[1] = 16'h0102;
        kick(8'h01, 16'd300, 8'd2);
        run_frame();
        build_exp(8'h01, 16'd300, 8'd2);
        compare_frame("nominal");
        for (int i = 0; i < 11; i++)
            if (i < got_q.size()) check($sformatf("nominal_lit%0d", i), 32'(got_q[i]), 32'(nom[i]));
        check("first_valid_clk", 32'(first_cyc), 32'd1);
        check("done_clk", 32'(done_cyc - first_cyc + 1), 32'd18);
        check_sel(8'd2);

        // Backpressure
        bp_en = 1;
        kick(8'h01, 16'd300, 8'd2);
        run_frame();
        bp_en = 0;
        bus.tx_ready = 1'b1;
        compare_frame("backpressure");
        check_sel(8'd2);

        // Range
        err_case(8'd0);
        err_case(8'd124);
        for (int i = 0; i < 256; i++) mem[i] = {8'(i) ^ 8'hA5, 8'(i * 3)};
        @(negedge clk);
        kick(8'h2F, 16'h8001, 8'd123);
        run_frame();
        build_exp(8'h2F, 16'h8001, 8'd123);
        compare_frame("max");
        check("max_len255", 32'(got_q.size()), 32'd255);
        if (got_q.size() > 6) check("max_bytecount", 32'(got_q[6]), 32'hF6);
        check_sel(8'd123);

        // Snapshot and ignored starts
        @(negedge clk);
        inj_a = 4;
        inj_b = 15;
        kick(8'h22, 16'h1234, 8'd3);
        run_frame();
        inj_a = 0;
        inj_b = 0;
        build_exp(8'h22, 16'h1234, 8'd3);
        compare_frame("snapshot");
        check_sel(8'd3);

        // Restart in the done cycle
        @(negedge clk);
        restart  = 1;
        rs_adr   = 8'h08;
        rs_first = 16'h0020;
        rs_num   = 8'd2;
        kick(8'h07, 16'h0010, 8'd1);
        run_frame();
        restart = 0;
        build_exp(8'h07, 16'h0010, 8'd1);
        compare_frame("restart_a");
        run_frame();
        check("restart_first_clk", 32'(first_cyc), 32'd1);
        build_exp(8'h08, 16'h0020, 8'd2);
        compare_frame("restart_b");

        // Reset during DHI, then a clean frame
        @(negedge clk);
        abort_at = 7;
        kick(8'h11, 16'h0002, 8'd2);
        run_frame();
        abort_at = -1;
        check("aborted", 32'(aborted), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        kick(8'h11, 16'h0002, 8'd2);
        run_frame();
        build_exp(8'h11, 16'h0002, 8'd2);
        compare_frame("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
